im_loader: RTL and testbench

- Write-side companion of the instruction memory. The CPU core only reads instruction memory; this block fills it.
- Accepts a framed byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes each word into instruction memory at incrementing addresses.
- Holds the core in reset until the whole program has loaded and its checksum has verified.

---
 rtl/mips_pkg.sv | 15 +
 rtl/im_loader_if.sv | 22 ++
 rtl/im_loader_byte_packer.sv | 36 +++
 rtl/im_loader.sv | 107 ++++++++++
 tb/tb_im_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface im_loader_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32
);
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   im_we;
    logic [ADDR_WIDTH-1:0]  im_address;
    logic [INSTR_WIDTH-1:0] im_data;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, im_we, im_address, im_data
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, im_we, im_address, im_data
    );
endinterface

// File: rtl/im_loader_byte_packer.sv
// Collects bytes MSB first into an instruction word; flags the accepting edge of the last byte.
module byte_packer
    import mips_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   asyn_n_rst,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   word_valid
);

    logic [INSTR_WIDTH-1:0] shift_reg;
    logic [1:0]             byte_cnt;

    // word is the value the shift register takes on this edge, so it can be written without a stall
    assign word       = {shift_reg[INSTR_WIDTH-9:0], byte_in};
    assign word_valid = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (shift_en) begin
            shift_reg <= word;
            byte_cnt  <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Loads a framed, XOR-checksummed byte stream into instruction memory and holds the core in reset until it verifies.
module im_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       asyn_n_rst,
    input  logic       start,
    im_loader_if.master bus,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic       done,
    output logic       error
);

    loader_state_t          state, next_state;
    logic [ADDR_WIDTH:0]    word_cnt;
    logic [7:0]             header;
    logic [7:0]             csum;
    logic                   load;
    logic                   xfer;
    logic                   last_word;
    logic                   cpu_rst_q;
    logic [INSTR_WIDTH-1:0] word;
    logic                   word_valid;

    assign bus.byte_ready = (state == HEADER) || (state == DATA) || (state == CHECK);
    assign xfer           = bus.byte_valid && bus.byte_ready;
    // word_cnt is one bit wider than the address so the final word (H=255) is still distinguishable
    assign last_word      = (word_cnt == (ADDR_WIDTH + 1)'(header));

    byte_packer #(
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_packer (
        .clk        (clk),
        .asyn_n_rst (asyn_n_rst),
        .clear      (load),
        .shift_en   (xfer && (state == DATA)),
        .byte_in    (bus.byte_in),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    next_state = HEADER;
                    load       = 1'b1;
                end
            end
            HEADER: if (xfer) next_state = DATA;
            DATA:   if (word_valid && last_word) next_state = CHECK;
            CHECK:  if (xfer) next_state = (bus.byte_in == csum) ? DONE : ERROR;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            state          <= IDLE;
            word_cnt       <= '0;
            header         <= '0;
            csum           <= '0;
            bus.im_we      <= 1'b0;
            bus.im_address <= '0;
            bus.im_data    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_rst_q      <= 1'b0;
        end else begin
            state     <= next_state;
            bus.im_we <= 1'b0;
            if (load) begin
                word_cnt <= '0;
                csum     <= '0;
            end
            if (state == HEADER && xfer) begin
                header <= bus.byte_in;
                csum   <= bus.byte_in;
            end
            if (state == DATA && xfer) begin
                csum <= csum ^ bus.byte_in;
            end
            if (word_valid) begin
                bus.im_we      <= 1'b1;
                bus.im_data    <= word;
                bus.im_address <= word_cnt[ADDR_WIDTH-1:0];
                word_cnt       <= word_cnt + 1'b1;
            end
            // status flags reflect the state being entered, so they change on the same edge as the state
            busy      <= (next_state == HEADER) || (next_state == DATA) || (next_state == CHECK);
            done      <= (next_state == DONE);
            error     <= (next_state == ERROR);
            cpu_rst_q <= (next_state == DONE);
        end
    end

    // Gating with the loader reset releases the core reset only while the loader itself is out of reset
    assign cpu_rst_n = cpu_rst_q & asyn_n_rst;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: per-cycle vector table plus multi-frame sequences.
module tb_im_loader;

    logic clk = 1'b0;
    logic asyn_n_rst;
    logic start;
    logic cpu_rst_n, busy, done, error;

    im_loader_if bus ();

    im_loader dut (
        .clk        (clk),
        .asyn_n_rst (asyn_n_rst),
        .start      (start),
        .bus        (bus),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] words[256];

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_addr_q.push_back(bus.im_address);
            wr_data_q.push_back(bus.im_data);
        end
    end

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  b;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        er;
        logic        cpu;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic vl, input logic [7:0] b,
                       input logic we, input logic [7:0] addr, input logic [31:0] data,
                       input logic rdy, input logic bsy, input logic dn, input logic er,
                       input logic cpu);
        vec_t v;
        v.st = st; v.vl = vl; v.b = b; v.we = we; v.addr = addr; v.data = data;
        v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.er = er; v.cpu = cpu;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, " byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, " im_we"},      32'(bus.im_we),      32'd0);
        check({tag, " im_address"}, 32'(bus.im_address), 32'd0);
        check({tag, " im_data"},    bus.im_data,         32'd0);
        check({tag, " cpu_rst_n"},  32'(cpu_rst_n),      32'd0);
        check({tag, " busy"},       32'(busy),           32'd0);
        check({tag, " done"},       32'(done),           32'd0);
        check({tag, " error"},      32'(error),          32'd0);
    endtask

    // Entered and left at a falling edge; one transfer per call.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("byte_ready timeout", 32'(bus.byte_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input bit bad, input int max_gap, input int start_at);
        logic [7:0] cs;
        logic [7:0] b;
        int idx;
        pulse_start();
        cs = h;
        send_byte(h, 0);
        idx = 0;
        for (int i = 0; i <= int'(h); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[i][31-8*k -: 8];
                cs = cs ^ b;
                if (idx == start_at) pulse_start();
                send_byte(b, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
                idx++;
            end
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cnt;
        logic [31:0] d;
        d = 32'h2001_0005;

        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        asyn_n_rst     = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_reset("reset");
        asyn_n_rst = 1'b1;
        @(negedge clk);

        // Single-word frame, bad-checksum frame, restart with a good frame
        add(1, 0, 8'h00, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
        add(0, 1, 8'h20, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
        add(0, 1, 8'h01, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
        add(1, 1, 8'h00, 0, 8'h00, 32'h0, 1, 1, 0, 0, 0);
        add(0, 1, 8'h05, 1, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h24, 0, 8'h00, d,     0, 0, 1, 0, 1);
        add(0, 1, 8'h55, 0, 8'h00, d,     0, 0, 1, 0, 1);
        add(1, 0, 8'h00, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h20, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h01, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h05, 1, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h25, 0, 8'h00, d,     0, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, d,     0, 0, 0, 1, 0);
        add(1, 0, 8'h00, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h20, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h01, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h05, 1, 8'h00, d,     1, 1, 0, 0, 0);
        add(0, 1, 8'h24, 0, 8'h00, d,     0, 0, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            start          = tbl[i].st;
            bus.byte_valid = tbl[i].vl;
            bus.byte_in    = tbl[i].b;
            @(negedge clk);
            start          = 1'b0;
            bus.byte_valid = 1'b0;
            check($sformatf("vec%0d im_we", i),      32'(bus.im_we),      32'(tbl[i].we));
            check($sformatf("vec%0d im_address", i), 32'(bus.im_address), 32'(tbl[i].addr));
            check($sformatf("vec%0d im_data", i),    bus.im_data,         tbl[i].data);
            check($sformatf("vec%0d byte_ready", i), 32'(bus.byte_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d busy", i),       32'(busy),           32'(tbl[i].bsy));
            check($sformatf("vec%0d done", i),       32'(done),           32'(tbl[i].dn));
            check($sformatf("vec%0d error", i),      32'(error),          32'(tbl[i].er));
            check($sformatf("vec%0d cpu_rst_n", i),  32'(cpu_rst_n),      32'(tbl[i].cpu));
        end
        check("table write count", 32'(wr_addr_q.size()), 32'd3);

        // Stalled stream: three words with random gaps
        wr_addr_q.delete(); wr_data_q.delete();
        words[0] = 32'h1122_3344; words[1] = 32'hA5A5_5A5A; words[2] = 32'hDEAD_BEEF;
        send_frame(8'h02, 1'b0, 5, -1);
        check("stall writes", 32'(wr_addr_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            check($sformatf("stall addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
            check($sformatf("stall data%0d", i), wr_data_q[i], words[i]);
        end
        check("stall done", 32'(done), 32'd1);
        check("stall cpu_rst_n", 32'(cpu_rst_n), 32'd1);

        // Full depth: 256 words, value = index
        wr_addr_q.delete(); wr_data_q.delete();
        for (int i = 0; i < 256; i++) words[i] = 32'(i);
        send_frame(8'hFF, 1'b0, 0, -1);
        check("full writes", 32'(wr_addr_q.size()), 32'd256);
        bad_cnt = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 32'(i)) bad_cnt++;
        check("full addr/data mismatches", 32'(bad_cnt), 32'd0);
        if (wr_addr_q.size() > 0) begin
            check("full last addr", 32'(wr_addr_q[$]), 32'h0000_00FF);
            check("full last data", wr_data_q[$], 32'h0000_00FF);
        end
        check("full done", 32'(done), 32'd1);
        check("full error", 32'(error), 32'd0);

        // start pulsed in the middle of the data phase
        wr_addr_q.delete(); wr_data_q.delete();
        words[0] = 32'hCAFE_F00D; words[1] = 32'h0123_4567;
        send_frame(8'h01, 1'b0, 1, 5);
        check("midstart writes", 32'(wr_addr_q.size()), 32'd2);
        if (wr_data_q.size() == 2) begin
            check("midstart data0", wr_data_q[0], 32'hCAFE_F00D);
            check("midstart data1", wr_data_q[1], 32'h0123_4567);
            check("midstart addr1", 32'(wr_addr_q[1]), 32'd1);
        end
        check("midstart done", 32'(done), 32'd1);

        // Reset after six data bytes, then a full reload
        wr_addr_q.delete(); wr_data_q.delete();
        words[0] = 32'h0A0B_0C0D; words[1] = 32'h1020_3040;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h0A, 0); send_byte(8'h0B, 0); send_byte(8'h0C, 0);
        send_byte(8'h0D, 0); send_byte(8'h10, 0); send_byte(8'h20, 0);
        check("pre-reset busy", 32'(busy), 32'd1);
        #1 asyn_n_rst = 1'b0;
        #1;
        check_outputs_reset("midreset");
        @(negedge clk);
        asyn_n_rst = 1'b1;
        @(negedge clk);
        check("post-reset byte_ready", 32'(bus.byte_ready), 32'd0);
        check("post-reset busy", 32'(busy), 32'd0);
        wr_addr_q.delete(); wr_data_q.delete();
        send_frame(8'h01, 1'b0, 0, -1);
        check("reload writes", 32'(wr_addr_q.size()), 32'd2);
        if (wr_data_q.size() == 2) begin
            check("reload addr0", 32'(wr_addr_q[0]), 32'd0);
            check("reload data1", wr_data_q[1], 32'h1020_3040);
        end
        check("reload done", 32'(done), 32'd1);
        check("reload cpu_rst_n", 32'(cpu_rst_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
